// File: rtl/comparador_serie.sv
// Bit-serial MSB-first magnitude comparator: one comparator cell reused over N clocks.
// Optional build macro COMPARADOR_SERIE_EARLY_EXIT_EN ends the scan at the first differing bit.
module comparador_serie #(
  parameter int N  = 8,
  parameter int CW = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [N-1:0] XIN,
  input  logic [N-1:0] YIN,
  output logic         BUSY,
  output logic         DONE,
  output logic         GT,
  output logic         EQ,
  output logic         LT
);

  // state  | meaning
  // S_IDLE | waiting for START; results from the last compare are held
  // S_RUN  | one cell per edge, MSB first, K/Z carry the decision
  // S_FIN  | publish GT/EQ/LT and pulse DONE on the way back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  sx_q, sx_d;
  logic [N-1:0]  sy_q, sy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          k_q, k_d;
  logic          z_q, z_d;
  logic          done_q, done_d;
  logic          gt_q, gt_d;
  logic          eq_q, eq_d;
  logic          lt_q, lt_d;
  logic          decide_now;
  logic          last_bit;

  assign decide_now = ~k_q & (sx_q[N-1] ^ sy_q[N-1]);
  assign last_bit   = (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      sx_q    <= '0;
      sy_q    <= '0;
      cnt_q   <= '0;
      k_q     <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      z_q     <= z_d;
      done_q  <= done_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    z_d     = z_q;
    done_d  = 1'b0;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          sx_d    = XIN;
          sy_d    = YIN;
          k_d     = 1'b0;
          z_d     = 1'b0;
          cnt_d   = CW'(N - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (decide_now) begin
          k_d = 1'b1;
          z_d = sx_q[N-1];
        end
        sx_d  = {sx_q[N-2:0], 1'b0};
        sy_d  = {sy_q[N-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
`ifdef COMPARADOR_SERIE_EARLY_EXIT_EN
        if (last_bit || decide_now) state_d = S_FIN;
`else
        if (last_bit) state_d = S_FIN;
`endif
      end
      S_FIN: begin
        done_d  = 1'b1;
        gt_d    = k_q & z_q;
        lt_d    = k_q & ~z_q;
        eq_d    = ~k_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY = (state_q != S_IDLE);
  assign DONE = done_q;
  assign GT   = gt_q;
  assign EQ   = eq_q;
  assign LT   = lt_q;

endmodule

// File: tb/tb_comparador_serie.sv
// Scoreboard bench for comparador_serie: stimulus pushes expected results, a monitor checks on DONE.
module tb_comparador_serie;
  localparam int N  = 8;
  localparam int CW = 4;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         START = 1'b0;
  logic [N-1:0] XIN = '0;
  logic [N-1:0] YIN = '0;
  logic         BUSY, DONE, GT, EQ, LT;

  comparador_serie #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .XIN(XIN), .YIN(YIN),
    .BUSY(BUSY), .DONE(DONE), .GT(GT), .EQ(EQ), .LT(LT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic gt;
    logic eq;
    logic lt;
    int   start_edge;
    int   lat;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_seen = 0;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Edges from START sample to DONE visible.
  function automatic int lat_of(input logic [N-1:0] x, input logic [N-1:0] y);
`ifdef COMPARADOR_SERIE_EARLY_EXIT_EN
    for (int i = 0; i < N; i++)
      if (x[N-1-i] != y[N-1-i]) return i + 2;
`endif
    return N + 1;
  endfunction

  always @(negedge CLK) begin
    if (DONE === 1'b1) begin
      done_seen++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got=1 want=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("gt", int'(GT), int'(e.gt));
        chk("eq", int'(EQ), int'(e.eq));
        chk("lt", int'(LT), int'(e.lt));
        chk("latency", cyc - e.start_edge, e.lat);
      end
    end
  end

  // Called away from the clock edge; returns #1 after the edge that sampled START.
  task automatic drive_start(input logic [N-1:0] x, input logic [N-1:0] y,
                             input bit push, input logic gt, input logic eq, input logic lt);
    exp_t e;
    START = 1'b1;
    XIN   = x;
    YIN   = y;
    if (push) begin
      e.gt = gt; e.eq = eq; e.lt = lt;
      e.start_edge = cyc + 1;
      e.lat = lat_of(x, y);
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
    START = 1'b0;
    XIN   = N'($urandom);
    YIN   = N'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got=%0d want=0 pending", q.size());
      q.delete();
    end
  endtask

  task automatic cmp(input logic [N-1:0] x, input logic [N-1:0] y);
    drive_start(x, y, 1'b1, x > y, x == y, x < y);
    wait_drain();
  endtask

  initial begin
    int busy_n;
    int d0;
    int n;

    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("rst_busy", int'(BUSY), 0);
      chk("rst_done", int'(DONE), 0);
      chk("rst_gt", int'(GT), 0);
      chk("rst_eq", int'(EQ), 0);
      chk("rst_lt", int'(LT), 0);
    end

    // Equal operands, with BUSY width measured.
    drive_start(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
    busy_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (BUSY) busy_n++;
    end
    chk("busy_cycles", busy_n, N + 1);
    wait_drain();

    drive_start(8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0); wait_drain();
    drive_start(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1); wait_drain();
    drive_start(8'hFE, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1); wait_drain();
    drive_start(8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0); wait_drain();
    drive_start(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0); wait_drain();
    drive_start(8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0); wait_drain();
    drive_start(8'h03, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0); wait_drain();

    // START during RUN is ignored; previous EQ result must stay visible meanwhile.
    drive_start(8'h20, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge CLK);
    #1;
    drive_start(8'hF0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    chk("hold_eq_during_run", int'(EQ), 1);
    chk("hold_lt_during_run", int'(LT), 0);

    // START in the DONE cycle is accepted.
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (DONE !== 1'b1 && n < 60);
    chk("done_seen_for_b2b", int'(DONE), 1);
    #1;
    drive_start(8'hC3, 8'hC2, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain();

    // Reset mid-RUN aborts without DONE.
    drive_start(8'h3C, 8'h3D, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    q.delete();
    d0 = done_seen;
    @(negedge CLK);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_gt", int'(GT), 0);
    chk("abort_eq", int'(EQ), 0);
    chk("abort_lt", int'(LT), 0);
    repeat (14) @(negedge CLK);
    chk("abort_no_done", done_seen, d0);
    #1;
    drive_start(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b1); wait_drain();

    // Sweep against the behavioural model.
    for (int x = 0; x < 256; x++) begin
      cmp(N'(x), N'(x));
      cmp(N'(x), N'(x) ^ 8'h01);
      cmp(N'(x), N'(x) ^ 8'h80);
      cmp(N'(x), N'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d want=0", cyc);
    $fatal(1, "timeout");
  end

endmodule
